// File: rtl/imm_decode_stage_if.sv
// Purpose: fetch-to-decode bus for the immediate-field decode stage (input handshake + decoded output bundle).
// Latency: wires only; no storage.
// Backpressure: in_ready and out_ready are plain valid/ready back-channels, one per direction.
//
// Ports (signals):
//   in_instr  [31:0] instruction word from fetch       in_valid / in_ready  input handshake
//   out_instr [31:0] instruction passed to decode      out_valid / out_ready output handshake
//   imm_field [25:0] right-aligned immediate field     imm_fmt [2:0] format code
//   imm_sign         sign-extend request               mov_shift [1:0] MOVZ hw field
// Modports: master = environment side (drives in_*, out_ready), slave = the stage.
interface imm_decode_stage_if;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_instr;
  logic [25:0] imm_field;
  logic [2:0]  imm_fmt;
  logic        imm_sign;
  logic [1:0]  mov_shift;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_instr, in_valid, out_ready,
    input  in_ready, out_instr, imm_field, imm_fmt, imm_sign, mov_shift, out_valid
  );

  modport slave (
    input  in_instr, in_valid, out_ready,
    output in_ready, out_instr, imm_field, imm_fmt, imm_sign, mov_shift, out_valid
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Purpose: classify LEGv8 immediate formats and extract the immediate field, buffered in a 2-entry skid stage.
// Latency: 1 cycle from accept to out_valid when empty; all outputs registered.
// Backpressure: 2-entry (main + skid) buffer; registered in_ready drops once both entries are full.
//
// Ports: clk, reset (async active-low), flush (sync kill of held entries),
//        bus (imm_decode_stage_if.slave): in_instr/in_valid/in_ready, out_* decoded bundle, out_valid/out_ready.
module imm_decode_stage (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  imm_decode_stage_if.slave bus
);

  localparam logic [2:0] FMT_NONE   = 3'd0;
  localparam logic [2:0] FMT_D9     = 3'd1;
  localparam logic [2:0] FMT_I12    = 3'd2;
  localparam logic [2:0] FMT_CB19   = 3'd3;
  localparam logic [2:0] FMT_B26    = 3'd4;
  localparam logic [2:0] FMT_MOV16  = 3'd5;
  localparam logic [2:0] FMT_SHAMT6 = 3'd6;

  typedef struct packed {
    logic [31:0] instr;
    logic [25:0] field;
    logic [2:0]  fmt;
    logic        sign;
    logic [1:0]  shift;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  dec_t   dec;
  dec_t   main_q;
  dec_t   skid_q;
  state_t state;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   accept;
  logic   emit;

  // Opcode classes are disjoint, so the order of the chain only matters for readability.
  always_comb begin
    dec       = '0;
    dec.instr = bus.in_instr;
    if (bus.in_instr[31:26] == 6'b000101 || bus.in_instr[31:26] == 6'b100101) begin
      dec.fmt   = FMT_B26;
      dec.field = bus.in_instr[25:0];
      dec.sign  = 1'b1;
    end else if (bus.in_instr[31:24] == 8'b10110100 || bus.in_instr[31:24] == 8'b10110101 ||
                 bus.in_instr[31:24] == 8'b01010100) begin
      dec.fmt   = FMT_CB19;
      dec.field = {7'd0, bus.in_instr[23:5]};
      dec.sign  = 1'b1;
    end else if (bus.in_instr[31:21] == 11'b11111000010 || bus.in_instr[31:21] == 11'b11111000000) begin
      dec.fmt   = FMT_D9;
      dec.field = {17'd0, bus.in_instr[20:12]};
      dec.sign  = 1'b1;
    end else if (bus.in_instr[31] && bus.in_instr[28:22] == 7'b1000100) begin
      // ADDI/ADDIS/SUBI/SUBIS differ only in bits 30:29
      dec.fmt   = FMT_I12;
      dec.field = {14'd0, bus.in_instr[21:10]};
    end else if (bus.in_instr[31:23] == 9'b110100101) begin
      dec.fmt   = FMT_MOV16;
      dec.field = {10'd0, bus.in_instr[20:5]};
      dec.shift = bus.in_instr[22:21];
    end else if (bus.in_instr[31:22] == 10'b1101001101) begin
      // LSL/LSR differ only in bit 21
      dec.fmt   = FMT_SHAMT6;
      dec.field = {20'd0, bus.in_instr[15:10]};
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign emit   = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // flush overrides any accept/emit in the same cycle
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q      <= dec;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q     <= dec;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (emit) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (emit) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = main_q.instr;
  assign bus.imm_field = main_q.field;
  assign bus.imm_fmt   = main_q.fmt;
  assign bus.imm_sign  = main_q.sign;
  assign bus.mov_shift = main_q.shift;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  imm_decode_stage_if bus ();

  imm_decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [25:0] field;
    logic [2:0]  fmt;
    logic        sign;
    logic [1:0]  shift;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    e.instr = w; e.field = '0; e.fmt = 3'd0; e.sign = 1'b0; e.shift = 2'd0;
    casez (w[31:21])
      11'b000101?????, 11'b100101?????: begin
        e.fmt = 3'd4; e.field = w[25:0]; e.sign = 1'b1;
      end
      11'b10110100???, 11'b10110101???, 11'b01010100???: begin
        e.fmt = 3'd3; e.field = 26'(w[23:5]); e.sign = 1'b1;
      end
      11'b11111000010, 11'b11111000000: begin
        e.fmt = 3'd1; e.field = 26'(w[20:12]); e.sign = 1'b1;
      end
      11'b1001000100?, 11'b1011000100?, 11'b1101000100?, 11'b1111000100?: begin
        e.fmt = 3'd2; e.field = 26'(w[21:10]);
      end
      11'b110100101??: begin
        e.fmt = 3'd5; e.field = 26'(w[20:5]); e.shift = w[22:21];
      end
      11'b11010011011, 11'b11010011010: begin
        e.fmt = 3'd6; e.field = 26'(w[15:10]);
      end
      default: ;
    endcase
    return e;
  endfunction

  // Scoreboard: handshakes are resolved at the falling edge, before the edge that commits them.
  always @(negedge clk) begin
    if (!reset || flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_instr", bus.out_instr, e.instr);
          chk("sb_field", 32'(bus.imm_field), 32'(e.field));
          chk("sb_fmt",   32'(bus.imm_fmt),   32'(e.fmt));
          chk("sb_sign",  32'(bus.imm_sign),  32'(e.sign));
          chk("sb_shift", 32'(bus.mov_shift), 32'(e.shift));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_instr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_instr"},     bus.out_instr,      32'd0);
    chk({tag, "_field"},     32'(bus.imm_field), 32'd0);
    chk({tag, "_fmt"},       32'(bus.imm_fmt),   32'd0);
    chk({tag, "_sign"},      32'(bus.imm_sign),  32'd0);
    chk({tag, "_shift"},     32'(bus.mov_shift), 32'd0);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr, input logic [25:0] field,
                         input logic [2:0] fmt, input logic sign);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_instr"}, bus.out_instr,      instr);
    chk({tag, "_field"}, 32'(bus.imm_field), 32'(field));
    chk({tag, "_fmt"},   32'(bus.imm_fmt),   32'(fmt));
    chk({tag, "_sign"},  32'(bus.imm_sign),  32'(sign));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pool [8];
    pool = '{32'hF85F8041, 32'h913FFC00, 32'h17FFFFFF, 32'hB4000041,
             32'h54000040, 32'hD2A00020, 32'hD3600C00, 32'h8B020020};

    reset = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // D9 decode
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'hF85F8041;
    tick();
    bus.in_valid = 1'b0;
    chk_out("d9", 32'hF85F8041, 26'h00001F8, 3'd1, 1'b1);
    tick();

    // I12, B26, NONE back-to-back
    bus.in_valid = 1'b1; bus.in_instr = 32'h913FFC00;
    tick();
    chk_out("i12", 32'h913FFC00, 26'hFFF, 3'd2, 1'b0);
    bus.in_instr = 32'h17FFFFFF;
    tick();
    chk_out("b26", 32'h17FFFFFF, 26'h3FFFFFF, 3'd4, 1'b1);
    bus.in_instr = 32'h00000000;
    tick();
    chk_out("none", 32'h00000000, 26'h0, 3'd0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: A, B fill both entries, C waits
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'hB4000041;
    tick();
    chk("bp_a_ready", 32'(bus.in_ready), 32'd1);
    bus.in_instr = 32'h54000040;
    tick();
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk_out("bp_a_hold", 32'hB4000041, 26'h2, 3'd3, 1'b1);
    bus.in_instr = 32'hD3600C00;
    tick();
    chk("bp_c_held_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk_out("bp_a_stable", 32'hB4000041, 26'h2, 3'd3, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    chk_out("bp_b_out", 32'h54000040, 26'h2, 3'd3, 1'b1);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    chk_out("bp_c_out", 32'hD3600C00, 26'h3, 3'd6, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Flush while full, with a new instruction offered in the same cycle
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h913FFC00;
    tick();
    bus.in_instr = 32'h17FFFFFF;
    tick();
    chk("fl_full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_instr = 32'hF85F8041; flush = 1'b1;
    tick();
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready",  32'(bus.in_ready),  32'd1);
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("fl_nothing_out", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset pulse while holding one entry
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'h913FFC00;
    tick();
    bus.in_valid = 1'b0;
    chk("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    #3 reset = 1'b0;
    #1 chk_reset_vals("midrst");
    #2 reset = 1'b1;
    tick();
    chk("rst_post_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'hD2800020;
    tick();
    bus.in_valid = 1'b0;
    chk_out("movz", 32'hD2800020, 26'h1, 3'd5, 1'b0);
    chk("movz_shift", 32'(bus.mov_shift), 32'd0);
    tick();

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_instr  = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 7)];
      flush         = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick();
    chk("drain_sb_empty",  32'(sb.size()),       32'd0);
    chk("drain_out_valid", 32'(bus.out_valid),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
